// File: rtl/writeback_stage_multi.sv
// Multi-lane in-order write-back stage: precise exception suppression, registered
// multi-cycle flush, retired-result bypass history, architectural flags and retire counter.
module writeback_stage_multi #(
   parameter int unsigned LANES        = 2,
   parameter int unsigned XLEN         = 32,
   parameter int unsigned RW           = 5,
   parameter int unsigned FW           = 4,
   parameter int unsigned CW           = 4,
   parameter int unsigned BYP_DEPTH    = 2,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned ZERO_REG     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LANES-1:0]                  inValid,
   output logic                              inStall,
   input  logic [LANES*RW-1:0]               inRd,
   input  logic [LANES*XLEN-1:0]             inRdVal,
   input  logic [LANES-1:0]                  inFlagsValid,
   input  logic [LANES*FW-1:0]               inFlags,
   input  logic [LANES-1:0]                  inMemNack,
   input  logic [LANES-1:0]                  inExValid,
   input  logic [LANES*CW-1:0]               inExCause,
   input  logic [LANES*XLEN-1:0]             inPc,
   output logic [LANES-1:0]                  wrEn,
   output logic [LANES*RW-1:0]               wrAddr,
   output logic [LANES*XLEN-1:0]             wrVal,
   output logic                              flush,
   output logic [CW-1:0]                     flushCause,
   output logic [XLEN-1:0]                   flushPc,
   output logic [BYP_DEPTH*LANES-1:0]        bypValid,
   output logic [BYP_DEPTH*LANES*RW-1:0]     bypRd,
   output logic [BYP_DEPTH*LANES*XLEN-1:0]   bypVal,
   output logic [FW-1:0]                     flags,
   output logic                              flagsValid,
   output logic [31:0]                       retireCount
);

   localparam int unsigned CNTW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                  state;
   logic [CNTW-1:0]         cnt;
   logic [LANES-1:0]        live;
   logic                    ex_found;
   logic [CW-1:0]           ex_cause;
   logic [XLEN-1:0]         ex_pc;
   logic                    fl_upd;
   logic [FW-1:0]           fl_nxt;
   logic [31:0]             retire_inc;

   logic [LANES-1:0]        byp_v   [BYP_DEPTH];
   logic [LANES*RW-1:0]     byp_rd  [BYP_DEPTH];
   logic [LANES*XLEN-1:0]   byp_val [BYP_DEPTH];

   assign inStall    = 1'b0;
   assign flagsValid = 1'b1;
   assign wrAddr     = inRd;
   assign wrVal      = inRdVal;

   // Lanes are scanned oldest first; once an excepting lane is seen it and every
   // younger lane lose liveness, and the last live flag writer (youngest) wins.
   always_comb begin
      ex_found   = 1'b0;
      ex_cause   = '0;
      ex_pc      = '0;
      live       = '0;
      wrEn       = '0;
      fl_upd     = 1'b0;
      fl_nxt     = flags;
      retire_inc = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (!ex_found && inValid[k] && (inMemNack[k] || inExValid[k])) begin
            ex_found = 1'b1;
            ex_cause = inMemNack[k] ? '0 : inExCause[k*CW +: CW];
            ex_pc    = inPc[k*XLEN +: XLEN];
         end
         live[k] = inValid[k] && !ex_found && !flush && rst;
         wrEn[k] = live[k] && !((ZERO_REG != 0) && (inRd[k*RW +: RW] == '0));
         if (live[k] && inFlagsValid[k]) begin
            fl_upd = 1'b1;
            fl_nxt = inFlags[k*FW +: FW];
         end
         retire_inc = retire_inc + 32'(live[k]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         flush      <= 1'b0;
         flushCause <= '0;
         flushPc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ex_found) begin
                  state      <= FLUSH;
                  flush      <= 1'b1;
                  cnt        <= CNTW'(FLUSH_CYCLES - 1);
                  flushCause <= ex_cause;
                  flushPc    <= ex_pc;
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags       <= '0;
         retireCount <= '0;
         for (int unsigned d = 0; d < BYP_DEPTH; d++) begin
            byp_v[d]   <= '0;
            byp_rd[d]  <= '0;
            byp_val[d] <= '0;
         end
      end else begin
         if (fl_upd) flags <= fl_nxt;
         retireCount <= retireCount + retire_inc;
         byp_v[0]    <= wrEn;
         byp_rd[0]   <= inRd;
         byp_val[0]  <= inRdVal;
         for (int unsigned d = 1; d < BYP_DEPTH; d++) begin
            byp_v[d]   <= byp_v[d-1];
            byp_rd[d]  <= byp_rd[d-1];
            byp_val[d] <= byp_val[d-1];
         end
      end
   end

   always_comb begin
      bypValid = '0;
      bypRd    = '0;
      bypVal   = '0;
      for (int unsigned d = 0; d < BYP_DEPTH; d++) begin
         bypValid[d*LANES +: LANES]       = byp_v[d];
         bypRd[d*LANES*RW +: LANES*RW]    = byp_rd[d];
         bypVal[d*LANES*XLEN +: LANES*XLEN] = byp_val[d];
      end
   end

endmodule

// File: tb/tb_writeback_stage_multi.sv
// Directed bench for writeback_stage_multi at default parameters (2 lanes, 2-deep bypass, 2-cycle flush).
module tb_writeback_stage_multi;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    inValid, inFlagsValid, inMemNack, inExValid;
   logic          inStall;
   logic [9:0]    inRd;
   logic [63:0]   inRdVal, inPc;
   logic [7:0]    inFlags, inExCause;
   logic [1:0]    wrEn;
   logic [9:0]    wrAddr;
   logic [63:0]   wrVal;
   logic          flush;
   logic [3:0]    flushCause;
   logic [31:0]   flushPc;
   logic [3:0]    bypValid;
   logic [19:0]   bypRd;
   logic [127:0]  bypVal;
   logic [3:0]    flags;
   logic          flagsValid;
   logic [31:0]   retireCount;

   int checks = 0;
   int errors = 0;

   writeback_stage_multi #(.LANES(2), .XLEN(32), .RW(5), .FW(4), .CW(4),
                           .BYP_DEPTH(2), .FLUSH_CYCLES(2), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inStall(inStall), .inRd(inRd),
      .inRdVal(inRdVal), .inFlagsValid(inFlagsValid), .inFlags(inFlags),
      .inMemNack(inMemNack), .inExValid(inExValid), .inExCause(inExCause), .inPc(inPc),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrVal(wrVal), .flush(flush), .flushCause(flushCause),
      .flushPc(flushPc), .bypValid(bypValid), .bypRd(bypRd), .bypVal(bypVal),
      .flags(flags), .flagsValid(flagsValid), .retireCount(retireCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      inValid = '0; inFlagsValid = '0; inMemNack = '0; inExValid = '0;
      inRd = '0; inRdVal = '0; inPc = '0; inFlags = '0; inExCause = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      idle_in();
      rst = 1'b0;
      inValid = 2'b11; inRd = {5'd5, 5'd3};
      #12;
      check("rst_wren", 64'(wrEn), 64'h0);
      check("rst_flush", 64'(flush), 64'h0);
      check("rst_flags", 64'(flags), 64'h0);
      check("rst_byp", 64'(bypValid), 64'h0);
      check("rst_retire", 64'(retireCount), 64'h0);
      check("stall_flagsv", 64'({inStall, flagsValid}), 64'h1);
      @(negedge clk); rst = 1'b1; idle_in();

      // two clean retires
      @(negedge clk);
      inValid = 2'b11; inRd = {5'd5, 5'd3}; inRdVal = {32'h22, 32'h11};
      #1;
      check("t1_wren", 64'(wrEn), 64'h3);
      check("t1_wraddr", 64'(wrAddr), 64'h0A3);
      check("t1_wrval", wrVal, 64'h00000022_00000011);
      step();
      check("t1_bypv", 64'(bypValid), 64'h3);
      check("t1_byprd", 64'(bypRd[9:0]), 64'h0A3);
      check("t1_bypval", bypVal[63:0], 64'h00000022_00000011);
      check("t1_retire", 64'(retireCount), 64'd2);
      @(negedge clk); idle_in();
      step();
      check("t1_shift_v", 64'(bypValid), 64'hC);
      check("t1_shift_rd", 64'(bypRd[19:10]), 64'h0A3);

      // lane1 exception, lane0 retires
      @(negedge clk);
      inValid = 2'b11; inRd = {5'd6, 5'd4}; inExValid = 2'b10;
      inExCause = {4'd7, 4'd0}; inPc = {32'h100, 32'h0FC};
      #1;
      check("t2_wren", 64'(wrEn), 64'h1);
      step();
      check("t2_flush1", 64'(flush), 64'h1);
      check("t2_cause", 64'(flushCause), 64'h7);
      check("t2_pc", 64'(flushPc), 64'h100);
      check("t2_retire", 64'(retireCount), 64'd3);
      @(negedge clk); idle_in();
      step();
      check("t2_flush2", 64'(flush), 64'h1);
      step();
      check("t2_flush_end", 64'(flush), 64'h0);

      // lane0 nack: cause forced to 0, wrong-path inputs ignored during flush
      @(negedge clk);
      inValid = 2'b11; inRd = {5'd6, 5'd4}; inMemNack = 2'b01;
      inExCause = {4'd0, 4'd5}; inPc = {32'h204, 32'h200};
      #1;
      check("t3_wren", 64'(wrEn), 64'h0);
      step();
      check("t3_flush", 64'(flush), 64'h1);
      check("t3_cause", 64'(flushCause), 64'h0);
      check("t3_pc", 64'(flushPc), 64'h200);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_in();
         inValid = 2'b11; inRd = {5'd8, 5'd7}; inFlagsValid = 2'b11; inFlags = 8'hFF;
         inExValid = 2'b10; inExCause = {4'd9, 4'd0}; inPc = {32'h300, 32'h2FC};
         #1;
         check("t3_wp_wren", 64'(wrEn), 64'h0);
         step();
         check("t3_wp_retire", 64'(retireCount), 64'd3);
         check("t3_wp_flags", 64'(flags), 64'h0);
      end
      check("t3_flush_end", 64'(flush), 64'h0);
      check("t3_no_recapture", 64'({flushCause, flushPc}), 64'h0_00000200);
      @(negedge clk); idle_in();
      step();
      check("t3_no_retrigger", 64'(flush), 64'h0);

      // flags: youngest live lane wins
      @(negedge clk);
      inValid = 2'b11; inRd = {5'd2, 5'd1}; inFlagsValid = 2'b11; inFlags = {4'h9, 4'h3};
      step();
      check("t4_flags", 64'(flags), 64'h9);
      check("t4_retire", 64'(retireCount), 64'd5);
      @(negedge clk);
      inExValid = 2'b10; inExCause = {4'd2, 4'd0};
      step();
      check("t5_flags", 64'(flags), 64'h3);
      check("t5_retire", 64'(retireCount), 64'd6);
      check("t5_flush", 64'(flush), 64'h1);
      @(negedge clk); idle_in();
      step(); step();
      check("t5_flush_end", 64'(flush), 64'h0);

      // rd=0 write suppressed but still retires; non-contiguous valid lanes
      @(negedge clk);
      inValid = 2'b01; inRd = {5'd9, 5'd0}; inRdVal = {32'h0, 32'h77};
      #1;
      check("t6_wren_r0", 64'(wrEn), 64'h0);
      step();
      check("t6_bypv", 64'(bypValid[1:0]), 64'h0);
      check("t6_retire", 64'(retireCount), 64'd7);
      @(negedge clk);
      inValid = 2'b10;
      #1;
      check("t6_wren_gap", 64'(wrEn), 64'h2);
      step();
      check("t6_retire2", 64'(retireCount), 64'd8);
      check("t6_bypv2", 64'(bypValid), 64'h2);

      // reset during flush aborts it
      @(negedge clk); idle_in();
      inValid = 2'b01; inExValid = 2'b01; inExCause = {4'd0, 4'd4}; inPc = {32'h0, 32'h300};
      step();
      check("t7_flush", 64'(flush), 64'h1);
      rst = 1'b0;
      #1;
      check("t7_rst_flush", 64'(flush), 64'h0);
      check("t7_rst_fc", 64'({flushCause, flushPc}), 64'h0);
      check("t7_rst_retire", 64'(retireCount), 64'h0);
      check("t7_rst_byp", 64'({bypValid, flags}), 64'h0);
      check("t7_rst_wren", 64'(wrEn), 64'h0);
      @(negedge clk); rst = 1'b1; idle_in();
      @(negedge clk);
      inValid = 2'b01; inRd = {5'd0, 5'd10}; inRdVal = {32'h0, 32'h55};
      #1;
      check("t7_post_wren", 64'(wrEn), 64'h1);
      step();
      check("t7_post_retire", 64'(retireCount), 64'd1);
      check("t7_post_bypv", 64'(bypValid[1:0]), 64'h1);
      check("t7_post_flush", 64'(flush), 64'h0);
      @(negedge clk); idle_in();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
